// File: rtl/trace_bram_sdp_pkg.sv
// Shared types and default sizing for the trace buffer block RAM.
// Optional feature macro (consumed by the top): TRB_BRAM_OUTREG_EN.
package trace_bram_sdp_pkg;

  localparam int TRB_WIDTH      = 32;
  localparam int TRB_DEPTH      = 1024;
  localparam int TRB_ADDR_WIDTH = $clog2(TRB_DEPTH);
  localparam int TRB_LANE_WIDTH = 8;

  typedef enum logic {RDW_READ_FIRST, RDW_WRITE_FIRST} rdw_mode_t;

  typedef enum logic {ST_CLEAR, ST_READY} clr_state_t;

endpackage

// File: rtl/trace_bram_sdp_if.sv
// Write/read port bundle of the trace buffer RAM; master drives requests, slave returns data.
interface trace_bram_sdp_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_LANES  = 4
);

  logic                  clr_busy;
  logic                  wr_en;
  logic [NUM_LANES-1:0]  wr_be;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WIDTH-1:0]      wr_data;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [WIDTH-1:0]      rd_data;
  logic                  rd_valid;

  modport master (
    output wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, clr_busy
  );

  modport slave (
    input  wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, clr_busy
  );

endinterface

// File: rtl/trace_bram_clr_ctrl.sv
// Post-reset clear sequencer: walks every address once, then stays ready until the next reset.
module trace_bram_clr_ctrl
  import trace_bram_sdp_pkg::*;
#(
  parameter int DEPTH = TRB_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     clr_busy,
  output logic [$clog2(DEPTH)-1:0] clr_addr,
  output logic                     clr_we
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);

  clr_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
        state_d = ST_READY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clr_busy = (state_q == ST_CLEAR);
  assign clr_we   = clr_busy;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/trace_bram_sdp.sv
// Simple-dual-port trace RAM with lane enables, post-reset clear and selectable RDW behaviour.
// Define TRB_BRAM_OUTREG_EN to add an output pipeline register (read latency 2 instead of 1).
module trace_bram_sdp
  import trace_bram_sdp_pkg::*;
#(
  parameter int        WIDTH      = TRB_WIDTH,
  parameter int        DEPTH      = TRB_DEPTH,
  parameter int        LANE_WIDTH = TRB_LANE_WIDTH,
  parameter rdw_mode_t RDW_MODE   = RDW_READ_FIRST
) (
  input logic              clk,
  input logic              reset,
  trace_bram_sdp_if.slave  bus
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int NUM_LANES  = WIDTH / LANE_WIDTH;

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("trace_bram_sdp: DEPTH must be a power of two and at least 2");
    end
    if (WIDTH % LANE_WIDTH != 0) begin : g_bad_width
      $error("trace_bram_sdp: WIDTH must be a multiple of LANE_WIDTH");
    end
  endgenerate

  logic                  clr_busy;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  trace_bram_clr_ctrl #(.DEPTH(DEPTH)) u_clr_ctrl (
    .clk      (clk),
    .reset    (reset),
    .clr_busy (clr_busy),
    .clr_addr (clr_addr),
    .clr_we   (clr_we)
  );

  logic [WIDTH-1:0]      mem [DEPTH];
  logic                  usr_wr;
  logic                  rd_go;
  logic                  mem_we;
  logic [NUM_LANES-1:0]  mem_be;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_wdata;

  // The clear sequencer owns the write port while busy; nothing touches the array during reset.
  always_comb begin
    usr_wr    = !reset && !clr_busy && bus.wr_en;
    rd_go     = !reset && !clr_busy && bus.rd_en;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset && clr_we) begin
      mem_we   = 1'b1;
      mem_be   = '1;
      mem_addr = clr_addr;
    end else if (usr_wr) begin
      mem_we    = 1'b1;
      mem_be    = bus.wr_be;
      mem_addr  = bus.wr_addr;
      mem_wdata = bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (mem_be[i]) begin
          mem[mem_addr][i*LANE_WIDTH +: LANE_WIDTH] <= mem_wdata[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  logic [WIDTH-1:0]     rd_raw_q;
  logic                 rd_valid_q, rd_valid_d;
  logic                 byp_hit_q, byp_hit_d;
  logic [NUM_LANES-1:0] byp_be_q, byp_be_d;
  logic [WIDTH-1:0]     byp_data_q, byp_data_d;
  logic [WIDTH-1:0]     rd_word;

  // The array read is always pre-write; write-first collisions are patched from captured write data.
  always_comb begin
    rd_valid_d = rd_go;
    byp_hit_d  = byp_hit_q;
    byp_be_d   = byp_be_q;
    byp_data_d = byp_data_q;
    if (rd_go) begin
      byp_hit_d  = (RDW_MODE == RDW_WRITE_FIRST) && usr_wr && (bus.wr_addr == bus.rd_addr);
      byp_be_d   = bus.wr_be;
      byp_data_d = bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_raw_q   <= '0;
      rd_valid_q <= 1'b0;
      byp_hit_q  <= 1'b0;
      byp_be_q   <= '0;
      byp_data_q <= '0;
    end else begin
      if (rd_go) begin
        rd_raw_q <= mem[bus.rd_addr];
      end
      rd_valid_q <= rd_valid_d;
      byp_hit_q  <= byp_hit_d;
      byp_be_q   <= byp_be_d;
      byp_data_q <= byp_data_d;
    end
  end

  always_comb begin
    rd_word = rd_raw_q;
    if (byp_hit_q) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (byp_be_q[i]) begin
          rd_word[i*LANE_WIDTH +: LANE_WIDTH] = byp_data_q[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

`ifdef TRB_BRAM_OUTREG_EN
  logic [WIDTH-1:0] rd_out_q, rd_out_d;
  logic             rd_out_valid_q;

  always_comb begin
    rd_out_d = rd_valid_q ? rd_word : rd_out_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_out_q       <= '0;
      rd_out_valid_q <= 1'b0;
    end else begin
      rd_out_q       <= rd_out_d;
      rd_out_valid_q <= rd_valid_q;
    end
  end

  assign bus.rd_data  = rd_out_q;
  assign bus.rd_valid = rd_out_valid_q;
`else
  assign bus.rd_data  = rd_word;
  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.clr_busy = clr_busy;

endmodule

// File: tb/tb_trace_bram_sdp.sv
// Bench for trace_bram_sdp: one read-first and one write-first instance driven identically,
// compared each cycle against an array-based reference model.
module tb_trace_bram_sdp;
  import trace_bram_sdp_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int NL    = 4;
`ifdef TRB_BRAM_OUTREG_EN
  localparam int RL = 2;
`else
  localparam int RL = 1;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [NL-1:0] wr_be = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [31:0]   wr_data = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  always #5 clk = ~clk;

  trace_bram_sdp_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .NUM_LANES(NL)) bus_rf ();
  trace_bram_sdp_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .NUM_LANES(NL)) bus_wf ();

  assign bus_rf.wr_en = wr_en;   assign bus_wf.wr_en = wr_en;
  assign bus_rf.wr_be = wr_be;   assign bus_wf.wr_be = wr_be;
  assign bus_rf.wr_addr = wr_addr; assign bus_wf.wr_addr = wr_addr;
  assign bus_rf.wr_data = wr_data; assign bus_wf.wr_data = wr_data;
  assign bus_rf.rd_en = rd_en;   assign bus_wf.rd_en = rd_en;
  assign bus_rf.rd_addr = rd_addr; assign bus_wf.rd_addr = rd_addr;

  trace_bram_sdp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANE_WIDTH(8), .RDW_MODE(RDW_READ_FIRST)) u_dut_rf (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_rf)
  );

  trace_bram_sdp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANE_WIDTH(8), .RDW_MODE(RDW_WRITE_FIRST)) u_dut_wf (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_wf)
  );

  // Reference model: plain word array, clear progress, and a per-stage view of in-flight reads.
  logic [31:0] model_mem [DEPTH];
  int          clr_pos = 0;
  logic        pv  [RL];
  logic [31:0] prf [RL];
  logic [31:0] pwf [RL];
  bit          chk_en = 1'b0;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_cycle();
    logic        busy_before;
    logic        issue;
    logic [31:0] old_w;
    logic [31:0] mrg_w;
    busy_before = (clr_pos < DEPTH);
    issue = !reset && !busy_before && rd_en;
    old_w = model_mem[rd_addr];
    mrg_w = old_w;
    if (!reset && !busy_before && wr_en && wr_addr == rd_addr) begin
      for (int l = 0; l < NL; l++) if (wr_be[l]) mrg_w[l*8 +: 8] = wr_data[l*8 +: 8];
    end
    @(posedge clk);
    if (reset) begin
      clr_pos = 0;
      chk_en  = 1'b1;
      for (int s = 0; s < RL; s++) begin
        pv[s] = 1'b0; prf[s] = '0; pwf[s] = '0;
      end
    end else begin
      for (int s = RL - 1; s > 0; s--) begin
        if (pv[s-1]) begin
          prf[s] = prf[s-1];
          pwf[s] = pwf[s-1];
        end
        pv[s] = pv[s-1];
      end
      if (issue) begin
        prf[0] = old_w;
        pwf[0] = mrg_w;
      end
      pv[0] = issue;
      if (busy_before) begin
        model_mem[clr_pos] = '0;
        clr_pos++;
      end else if (wr_en) begin
        for (int l = 0; l < NL; l++) if (wr_be[l]) model_mem[wr_addr][l*8 +: 8] = wr_data[l*8 +: 8];
      end
    end
    #1;
    if (chk_en) begin
      check("busy_rf",  {31'b0, bus_rf.clr_busy}, {31'b0, clr_pos < DEPTH});
      check("busy_wf",  {31'b0, bus_wf.clr_busy}, {31'b0, clr_pos < DEPTH});
      check("valid_rf", {31'b0, bus_rf.rd_valid}, {31'b0, pv[RL-1]});
      check("valid_wf", {31'b0, bus_wf.rd_valid}, {31'b0, pv[RL-1]});
      check("data_rf",  bus_rf.rd_data, prf[RL-1]);
      check("data_wf",  bus_wf.rd_data, pwf[RL-1]);
    end
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
    do_cycle();
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [31:0] d, input logic [NL-1:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    rd_en = 1'b0;
    do_cycle();
    wr_en = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [AW-1:0] a,
                            input logic [31:0] exp_rf, input logic [31:0] exp_wf);
    rd_en = 1'b1; rd_addr = a; wr_en = 1'b0;
    do_cycle();
    rd_en = 1'b0;
    repeat (RL - 1) do_cycle();
    check({tag, "_valid"}, {31'b0, bus_rf.rd_valid}, 32'd1);
    check({tag, "_rf"}, bus_rf.rd_data, exp_rf);
    check({tag, "_wf"}, bus_wf.rd_data, exp_wf);
  endtask

  initial begin
    int busy_cnt;
    int vcnt;
    int first_v;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    for (int s = 0; s < RL; s++) begin
      pv[s] = 1'b0; prf[s] = '0; pwf[s] = '0;
    end

    // Clear sequence; reads issued during clear must be ignored.
    reset = 1'b1;
    do_cycle();
    reset = 1'b0;
    busy_cnt = 0;
    while (bus_rf.clr_busy && busy_cnt < 40) begin
      rd_en = 1'b1; rd_addr = AW'(busy_cnt);
      do_cycle();
      busy_cnt++;
    end
    rd_en = 1'b0;
    check("clear_len", busy_cnt, DEPTH);
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 1'b1; rd_addr = AW'(a);
      do_cycle();
    end
    idle();
    idle();

    // Lane-masked writes followed immediately by a read.
    write_word(4'd3, 32'hAABBCCDD, 4'b1111);
    write_word(4'd3, 32'h11223344, 4'b0101);
    read_check("lane_merge", 4'd3, 32'hAA22CC44, 32'hAA22CC44);

    // Same-address collision.
    write_word(4'd5, 32'h01020304, 4'b1111);
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hFFFFFFFF; wr_be = 4'b0011;
    rd_en = 1'b1; rd_addr = 4'd5;
    do_cycle();
    wr_en = 1'b0; rd_en = 1'b0;
    repeat (RL - 1) do_cycle();
    check("collide_rf", bus_rf.rd_data, 32'h01020304);
    check("collide_wf", bus_wf.rd_data, 32'h0102FFFF);
    read_check("after_collide", 4'd5, 32'h0102FFFF, 32'h0102FFFF);

    // Latency and burst throughput.
    for (int a = 0; a < 4; a++) write_word(AW'(a + 8), 32'hC0DE0000 | a, 4'b1111);
    vcnt = 0;
    first_v = -1;
    for (int k = 1; k <= 4 + RL; k++) begin
      rd_en = (k <= 4); rd_addr = AW'(k + 7);
      do_cycle();
      if (bus_rf.rd_valid) begin
        vcnt++;
        if (first_v < 0) first_v = k;
      end
    end
    rd_en = 1'b0;
    check("burst_count", vcnt, 4);
    check("burst_latency", first_v, RL);

    // Reset mid-clear, with writes to addr 2 attempted while clearing.
    write_word(4'd2, 32'h55AA55AA, 4'b1111);
    reset = 1'b1;
    do_cycle();
    reset = 1'b0;
    repeat (7) do_cycle();
    reset = 1'b1;
    do_cycle();
    reset = 1'b0;
    busy_cnt = 0;
    while (bus_rf.clr_busy && busy_cnt < 40) begin
      wr_en = (busy_cnt >= 8); wr_addr = 4'd2; wr_data = 32'hDEADBEEF; wr_be = 4'b1111;
      do_cycle();
      busy_cnt++;
    end
    wr_en = 1'b0;
    check("reclear_len", busy_cnt, DEPTH);
    read_check("addr2_cleared", 4'd2, 32'h0, 32'h0);

    // Randomized traffic with frequent collisions and one reset from the ready state.
    for (int i = 0; i < 300; i++) begin
      reset   = (i == 150);
      wr_en   = 1'($urandom_range(0, 1));
      wr_be   = NL'($urandom_range(0, 15));
      wr_addr = AW'($urandom_range(0, DEPTH - 1));
      wr_data = $urandom;
      rd_en   = 1'($urandom_range(0, 1));
      rd_addr = ($urandom_range(0, 1) == 1) ? wr_addr : AW'($urandom_range(0, DEPTH - 1));
      do_cycle();
    end
    reset = 1'b0;
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
